// File: rtl/div_sequencer.sv
// Signed restoring divider sequencer: drives an external shared adder one add per cycle
// for operand negation, WIDTH trial subtractions, and quotient/remainder sign fix-up.
module div_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NEG_A = 3'd1,
      S_NEG_B = 3'd2,
      S_ITER  = 3'd3,
      S_SGN_Q = 3'd4,
      S_SGN_R = 3'd5,
      S_DONE  = 3'd6,
      S_ZERO  = 3'd7
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a_mag;
   logic [WIDTH-1:0] r_d_mag;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic             r_sign_q;
   logic             r_sign_r;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;
   logic [WIDTH-1:0] w_shift;
   logic             w_success;
   logic             w_divisor_zero;

   // A carry out of R's top bit means the shifted remainder already exceeds any divisor.
   assign w_shift        = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
   assign w_success      = r_rem[WIDTH-1] | add_cout;
   assign w_divisor_zero = (divisor == {WIDTH{1'b0}});

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);
   assign div_by_zero = r_div_by_zero;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;

   // State register.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and adder operands; operands depend only on state and registers.
   always_comb begin
      w_next_state = r_state;
      add_a        = {WIDTH{1'b0}};
      add_b        = {WIDTH{1'b0}};
      add_cin      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_divisor_zero) begin
                  w_next_state = S_ZERO;
               end else begin
                  w_next_state = S_NEG_A;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_NEG_A: begin
            add_a        = r_a_mag[WIDTH-1] ? ~r_a_mag : r_a_mag;
            add_cin      = r_a_mag[WIDTH-1];
            w_next_state = S_NEG_B;
         end
         S_NEG_B: begin
            add_a        = r_d_mag[WIDTH-1] ? ~r_d_mag : r_d_mag;
            add_cin      = r_d_mag[WIDTH-1];
            w_next_state = S_ITER;
         end
         S_ITER: begin
            add_a   = w_shift;
            add_b   = ~r_d_mag;
            add_cin = 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_next_state = S_SGN_Q;
            end else begin
               w_next_state = S_ITER;
            end
         end
         S_SGN_Q: begin
            add_a        = r_sign_q ? ~r_quo : r_quo;
            add_cin      = r_sign_q;
            w_next_state = S_SGN_R;
         end
         S_SGN_R: begin
            add_a        = r_sign_r ? ~r_rem : r_rem;
            add_cin      = r_sign_r;
            w_next_state = S_DONE;
         end
         S_ZERO:  w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Datapath registers, updated according to the current state.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_a_mag       <= {WIDTH{1'b0}};
         r_d_mag       <= {WIDTH{1'b0}};
         r_rem         <= {WIDTH{1'b0}};
         r_quo         <= {WIDTH{1'b0}};
         r_sign_q      <= 1'b0;
         r_sign_r      <= 1'b0;
         r_cnt         <= {CNT_W{1'b0}};
         r_quotient    <= {WIDTH{1'b0}};
         r_remainder   <= {WIDTH{1'b0}};
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_mag  <= dividend;
                  r_d_mag  <= divisor;
                  r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_sign_r <= dividend[WIDTH-1];
                  if (w_divisor_zero) begin
                     r_quotient    <= {WIDTH{1'b0}};
                     r_remainder   <= dividend;
                     r_div_by_zero <= 1'b1;
                  end else begin
                     r_div_by_zero <= 1'b0;
                  end
               end
            end
            S_NEG_A: r_a_mag <= add_sum;
            S_NEG_B: begin
               r_d_mag <= add_sum;
               r_quo   <= r_a_mag;
               r_rem   <= {WIDTH{1'b0}};
               r_cnt   <= {CNT_W{1'b0}};
            end
            S_ITER: begin
               if (w_success) begin
                  r_rem <= add_sum;
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift;
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_SGN_Q: r_quotient  <= add_sum;
            S_SGN_R: r_remainder <= add_sum;
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: behavioural adder, queued expected results
// compared on every done pulse, plus per-scenario timing and reset checks.
module tb_div_sequencer;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_sum;
   logic        add_cout;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   logic [64:0] sb_q[$];   // {div_by_zero, quotient, remainder}

   div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .quotient(quotient),
      .remainder(remainder), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   always #5 clk = ~clk;

   function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] q;
      logic signed [31:0] r;
      if (b == 32'd0) begin
         model = {1'b1, 32'd0, a};
      end else if (b == 32'hFFFFFFFF) begin
         model = {1'b0, 32'd0 - a, 32'd0};
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
         model = {1'b0, q, r};
      end
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   initial begin
      logic [64:0] exp;
      forever begin
         @(negedge clk);
         if (clr_n === 1'b1 && done === 1'b1) begin
            n_done = n_done + 1;
            if (sb_q.size() == 0) begin
               n_checks = n_checks + 1;
               n_errors = n_errors + 1;
               $display("FAIL unexpected_done: q=%h r=%h, no result was expected", quotient, remainder);
            end else begin
               exp = sb_q.pop_front();
               n_checks = n_checks + 3;
               if (quotient !== exp[63:32]) begin
                  n_errors = n_errors + 1;
                  $display("FAIL quotient: got %h, expected %h", quotient, exp[63:32]);
               end
               if (remainder !== exp[31:0]) begin
                  n_errors = n_errors + 1;
                  $display("FAIL remainder: got %h, expected %h", remainder, exp[31:0]);
               end
               if (div_by_zero !== exp[64]) begin
                  n_errors = n_errors + 1;
                  $display("FAIL div_by_zero: got %b, expected %b", div_by_zero, exp[64]);
               end
            end
         end
      end
   end

   // Caller sits just after a rising edge with the DUT idle; returns just after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [64:0] exp);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int i;
      i = 0;
      while (n_done < target && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      n_checks++;
      if (n_done < target) begin
         n_errors++;
         $display("FAIL wait_done: done count %0d, expected %0d", n_done, target);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, div_by_zero, quotient, remainder, add_a, add_b, add_cin} !== 134'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h a=%h b=%h cin=%b, expected all 0",
                  busy, done, div_by_zero, quotient, remainder, add_a, add_b, add_cin);
      end
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, quotient, remainder} !== 66'd0) begin
         n_errors++;
         $display("FAIL reset_release: busy=%b done=%b q=%h r=%h, expected 0", busy, done, quotient, remainder);
      end
   endtask

   task automatic test_latency();
      int   base;
      logic exp_done;
      logic exp_busy;
      base = n_done;
      issue(32'd100, 32'd7, {1'b0, 32'd14, 32'd2});
      for (int cyc = 0; cyc <= 37; cyc++) begin
         @(negedge clk);
         exp_done = (cyc == 36);
         exp_busy = (cyc < 37);
         n_checks += 2;
         if (done !== exp_done) begin
            n_errors++;
            $display("FAIL latency_done at E%0d: got %b, expected %b", cyc, done, exp_done);
         end
         if (busy !== exp_busy) begin
            n_errors++;
            $display("FAIL latency_busy at E%0d: got %b, expected %b", cyc, busy, exp_busy);
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (n_done !== base + 1) begin
         n_errors++;
         $display("FAIL latency_done_count: got %0d, expected %0d", n_done - base, 1);
      end
   endtask

   task automatic test_signs();
      int          base;
      logic [31:0] a;
      logic [31:0] b;
      base = n_done;
      issue(32'hFFFFFF9C, 32'd7, {1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE});
      wait_done(base + 1);
      issue(32'd100, 32'hFFFFFFF9, {1'b0, 32'hFFFFFFF2, 32'd2});
      wait_done(base + 2);
      issue(32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h80000000, 32'd0});
      wait_done(base + 3);
      issue(32'hFFFFFF9C, 32'hFFFFFFF9, {1'b0, 32'd14, 32'hFFFFFFFE});
      wait_done(base + 4);
      issue(32'd7, 32'd100, {1'b0, 32'd0, 32'd7});
      wait_done(base + 5);
      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(31, 0);
         issue(a, b, model(a, b));
         wait_done(base + 6 + k);
      end
   endtask

   task automatic test_div_zero();
      int   base;
      logic exp_done;
      logic exp_busy;
      base = n_done;
      issue(32'h12345678, 32'd0, {1'b1, 32'd0, 32'h12345678});
      for (int cyc = 0; cyc <= 2; cyc++) begin
         @(negedge clk);
         exp_done = (cyc == 1);
         exp_busy = (cyc < 2);
         n_checks += 3;
         if (done !== exp_done) begin
            n_errors++;
            $display("FAIL dbz_done at E%0d: got %b, expected %b", cyc, done, exp_done);
         end
         if (busy !== exp_busy) begin
            n_errors++;
            $display("FAIL dbz_busy at E%0d: got %b, expected %b", cyc, busy, exp_busy);
         end
         if ({add_a, add_b, add_cin} !== 65'd0) begin
            n_errors++;
            $display("FAIL dbz_adder at E%0d: a=%h b=%h cin=%b, expected 0", cyc, add_a, add_b, add_cin);
         end
         @(posedge clk);
         #1;
      end
      n_checks += 2;
      if (n_done !== base + 1) begin
         n_errors++;
         $display("FAIL dbz_done_count: got %0d, expected 1", n_done - base);
      end
      if (div_by_zero !== 1'b1) begin
         n_errors++;
         $display("FAIL dbz_held: got %b, expected 1", div_by_zero);
      end
   endtask

   task automatic test_back_to_back();
      int base;
      base = n_done;
      issue(32'd1000, 32'd3, {1'b0, 32'd333, 32'd1});
      for (int k = 0; k < 5; k++) begin
         repeat (3) @(posedge clk);
         #1;
         dividend = $urandom;
         divisor  = 32'd5;
         start    = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_done(base + 1);
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (n_done !== base + 1) begin
         n_errors++;
         $display("FAIL busy_start_ignored: got %0d dones, expected 1", n_done - base);
      end
      // start held high across two operations
      base = n_done;
      dividend = 32'd50;
      divisor  = 32'd6;
      sb_q.push_back({1'b0, 32'd8, 32'd2});
      sb_q.push_back({1'b0, 32'd8, 32'd2});
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
      n_checks++;
      if (done !== 1'b1) begin
         n_errors++;
         $display("FAIL held_first_done: got %b, expected 1", done);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL held_idle_gap: busy got %b, expected 0", busy);
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL held_reaccept: busy got %b, expected 1", busy);
      end
      start = 1'b0;
      wait_done(base + 2);
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (n_done !== base + 2 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL held_done_count: got %0d dones busy=%b, expected 2 dones busy=0", n_done - base, busy);
      end
   endtask

   task automatic test_reset_mid();
      int base;
      base = n_done;
      dividend = 32'd123456;
      divisor  = 32'd789;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      clr_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, div_by_zero, quotient, remainder, add_a, add_b, add_cin} !== 134'd0) begin
         n_errors++;
         $display("FAIL midop_reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h a=%h b=%h cin=%b, expected all 0",
                  busy, done, div_by_zero, quotient, remainder, add_a, add_b, add_cin);
      end
      repeat (3) @(posedge clk);
      #1;
      clr_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (n_done !== base || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL midop_no_done: got %0d dones busy=%b, expected 0 dones busy=0", n_done - base, busy);
      end
      issue(32'h7FFFFFFF, 32'h80000000, {1'b0, 32'd0, 32'h7FFFFFFF});
      wait_done(base + 1);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_signs();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
